// File: rtl/ram_2x8_ctrl_if.sv
// ram_2x8_ctrl_if: command/response handshake bundle for the ram_2x8 controller.
//
// Signals
//   cmd_valid / cmd_ready  command handshake
//   cmd_write              1 = write, 0 = read
//   cmd_addr               target RAM location (2 bits; values >= NUM_LOC are errors)
//   cmd_data               write data
//   rsp_valid / rsp_ready  response handshake
//   rsp_data               read data, or echoed write data
//   rsp_err                command failed
//
// Modports
//   master  command issuer / response consumer
//   slave   the controller
interface ram_2x8_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [1:0]        cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ram_2x8_ctrl.sv
// ram_2x8_ctrl: request/response front-end for the 2-location x 8-bit RAM (ram_2x8).
// Accepts one read/write command at a time, sequences the RAM pins, captures read data
// and returns one response per command. Optionally zero-fills the RAM after reset.
//
// Ports
//   clock         system clock, rising edge
//   clear         synchronous reset, active-low
//   bus           ram_2x8_ctrl_if.slave: cmd_* / rsp_* handshakes
//   busy          high in every state except idle
//   mem_rw        RAM rw (1 = write); high only in the two init states and the write state
//   mem_endereco  RAM address; holds its last value, never 2 or 3
//   mem_data_in   RAM write data; holds its last value
//   mem_data_out  RAM read data
//
// Optional feature: define RAM_2X8_CTRL_READBACK_VERIFY_EN to read each written word
// back (two extra cycles) and flag rsp_err when the readback differs.
module ram_2x8_ctrl #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned NUM_LOC       = 2,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              clear,
    ram_2x8_ctrl_if.slave     bus,
    output logic              busy,
    output logic              mem_rw,
    output logic [1:0]        mem_endereco,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // StReset is where the block sits while clear is low; it keeps every output quiet so
    // no RAM write can be issued until clear has been released.
    typedef enum logic [3:0] {
        StReset,
        StInit0,
        StInit1,
        StIdle,
        StWr,
        StRdA,
        StRdC,
        StResp
`ifdef RAM_2X8_CTRL_READBACK_VERIFY_EN
        ,
        StVfA,
        StVfC
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              addr_oor;

    assign addr_oor = 32'(bus.cmd_addr) >= NUM_LOC;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            StReset: begin
                if (INIT_ON_RESET) begin
                    state_d = StInit0;
                    addr_d  = 2'd0;
                    wdata_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StInit0: begin
                state_d = StInit1;
                addr_d  = 2'd1;
                wdata_d = '0;
            end
            StInit1: state_d = StIdle;
            StIdle: begin
                // cmd_ready is high only here, so cmd_valid alone marks an accept.
                if (bus.cmd_valid) begin
                    if (addr_oor) begin
                        state_d    = StResp;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        addr_d = bus.cmd_addr;
                        if (bus.cmd_write) begin
                            wdata_d = bus.cmd_data;
                            state_d = StWr;
                        end else begin
                            state_d = StRdA;
                        end
                    end
                end
            end
            StWr: begin
                rsp_data_d = wdata_q;
                rsp_err_d  = 1'b0;
`ifdef RAM_2X8_CTRL_READBACK_VERIFY_EN
                state_d    = StVfA;
`else
                state_d    = StResp;
`endif
            end
            StRdA: state_d = StRdC;
            StRdC: begin
                rsp_data_d = mem_data_out;
                rsp_err_d  = 1'b0;
                state_d    = StResp;
            end
`ifdef RAM_2X8_CTRL_READBACK_VERIFY_EN
            StVfA: state_d = StVfC;
            StVfC: begin
                rsp_err_d = (mem_data_out != wdata_q);
                state_d   = StResp;
            end
`endif
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q    <= StReset;
            addr_q     <= 2'd0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        bus.cmd_ready = (state_q == StIdle);
        busy          = (state_q != StIdle);
        bus.rsp_valid = (state_q == StResp);
        mem_rw        = (state_q == StInit0) || (state_q == StInit1) || (state_q == StWr);
    end

    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign mem_endereco  = addr_q;
    assign mem_data_in   = wdata_q;

endmodule

// File: tb/tb_ram_2x8_ctrl.sv
// tb_ram_2x8_ctrl: directed self-checking bench for ram_2x8_ctrl with a small behavioural
// model of the 2x8 RAM (combinational read, write on rising edge when rw=1).
module tb_ram_2x8_ctrl;

`ifdef RAM_2X8_CTRL_READBACK_VERIFY_EN
    localparam int WrLat = 3;
`else
    localparam int WrLat = 1;
`endif

    logic       clock = 1'b0;
    logic       clear;
    logic       busy;
    logic       mem_rw;
    logic [1:0] mem_endereco;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic       force_zero;

    int n_checks = 0;
    int n_fail   = 0;

    // Non-zero power-up contents so the zero-fill is observable.
    logic [7:0] ram [2] = '{8'hEE, 8'hEE};

    ram_2x8_ctrl_if #(.DATA_W(8)) bus ();

    ram_2x8_ctrl #(
        .DATA_W       (8),
        .NUM_LOC      (2),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .bus         (bus),
        .busy        (busy),
        .mem_rw      (mem_rw),
        .mem_endereco(mem_endereco),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_rw) ram[mem_endereco[0]] <= mem_data_in;
    end

    assign mem_data_out = force_zero ? 8'h00 : ram[mem_endereco[0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one command and wait (bounded) for rsp_valid; leaves the response pending.
    task automatic issue_cmd(input string tag, input logic wr, input logic [1:0] addr,
                             input logic [7:0] data, output int lat, output logic saw_rw);
        check_eq({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
        lat    = 0;
        saw_rw = mem_rw;
        while (!bus.rsp_valid && lat < 10) begin
            tick();
            lat++;
            saw_rw = saw_rw | mem_rw;
        end
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_eq({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
        check_eq({tag, "_idle"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic wr, input logic [1:0] addr,
                           input logic [7:0] data, input int exp_lat, input logic [7:0] exp_data,
                           input logic exp_err, input logic exp_rw);
        int   lat;
        logic saw_rw;
        issue_cmd(tag, wr, addr, data, lat, saw_rw);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
        check_eq({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check_eq({tag, "_rw"}, 32'(saw_rw), 32'(exp_rw));
        finish_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        logic saw_rw;

        clear         = 1'b0;
        force_zero    = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 2'd0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
        check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_eq("rst_mem_rw", 32'(mem_rw), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_endereco), 32'd0);
        check_eq("rst_mem_din", 32'(mem_data_in), 32'h00);

        // Zero-fill: two write cycles at addresses 0 then 1, ready on the third cycle
        clear = 1'b1;
        tick();
        check_eq("init0_rw", 32'(mem_rw), 32'd1);
        check_eq("init0_addr", 32'(mem_endereco), 32'd0);
        check_eq("init0_din", 32'(mem_data_in), 32'h00);
        check_eq("init0_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        check_eq("init1_rw", 32'(mem_rw), 32'd1);
        check_eq("init1_addr", 32'(mem_endereco), 32'd1);
        check_eq("init1_din", 32'(mem_data_in), 32'h00);
        check_eq("init1_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        check_eq("idle_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_rw", 32'(mem_rw), 32'd0);

        run_cmd("rd0_init", 1'b0, 2'd0, 8'h00, 2, 8'h00, 1'b0, 1'b0);
        run_cmd("wr1_a5", 1'b1, 2'd1, 8'hA5, WrLat, 8'hA5, 1'b0, 1'b1);
        run_cmd("rd1_a5", 1'b0, 2'd1, 8'h00, 2, 8'hA5, 1'b0, 1'b0);
        run_cmd("rd0_00", 1'b0, 2'd0, 8'h00, 2, 8'h00, 1'b0, 1'b0);

        // Out-of-range addresses: immediate error response, RAM untouched
        run_cmd("wr2_oor", 1'b1, 2'd2, 8'h3C, 0, 8'h00, 1'b1, 1'b0);
        run_cmd("rd3_oor", 1'b0, 2'd3, 8'h00, 0, 8'h00, 1'b1, 1'b0);

        // Response stall with a competing command that must be ignored
        run_cmd("wr0_5a", 1'b1, 2'd0, 8'h5A, WrLat, 8'h5A, 1'b0, 1'b1);
        issue_cmd("rd0_stall", 1'b0, 2'd0, 8'h00, lat, saw_rw);
        check_eq("rd0_stall_lat", 32'(lat), 32'd2);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 2'd1;
        bus.cmd_data  = 8'h11;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("stall_data", 32'(bus.rsp_data), 32'h5A);
            check_eq("stall_ready", 32'(bus.cmd_ready), 32'd0);
            check_eq("stall_rw", 32'(mem_rw), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        finish_rsp("rd0_stall");
        run_cmd("rd1_after_stall", 1'b0, 2'd1, 8'h00, 2, 8'hA5, 1'b0, 1'b0);

        // Reset asserted during the write cycle
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 2'd0;
        bus.cmd_data  = 8'hFF;
        tick();
        bus.cmd_valid = 1'b0;
        check_eq("wrff_rw", 32'(mem_rw), 32'd1);
        check_eq("wrff_addr", 32'(mem_endereco), 32'd0);
        check_eq("wrff_din", 32'(mem_data_in), 32'hFF);
        clear = 1'b0;
        tick();
        check_eq("abort_rw", 32'(mem_rw), 32'd0);
        check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd1);
        check_eq("abort_din", 32'(mem_data_in), 32'h00);
        clear = 1'b1;
        tick();
        tick();
        tick();
        check_eq("reinit_ready", 32'(bus.cmd_ready), 32'd1);
        run_cmd("rd0_after_abort", 1'b0, 2'd0, 8'h00, 2, 8'h00, 1'b0, 1'b0);
        run_cmd("rd1_after_abort", 1'b0, 2'd1, 8'h00, 2, 8'h00, 1'b0, 1'b0);

`ifdef RAM_2X8_CTRL_READBACK_VERIFY_EN
        // Readback corrupted to 0x00: error flagged, written data still echoed
        force_zero = 1'b1;
        run_cmd("wr0_81_vf", 1'b1, 2'd0, 8'h81, 3, 8'h81, 1'b1, 1'b1);
        force_zero = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_2x8_ctrl.md
Name: ram_2x8_ctrl

Overview:
- Request/response front-end that sits directly upstream of the 2-location x 8-bit RAM (ram_2x8) and is the only block driving its rw/endereco/data_in.
- Accepts single read/write commands over a valid/ready handshake, sequences the RAM control pins, captures read data, and returns one response per command.
- Zero-initialises both locations after reset, rejects out-of-range addresses, and allows only one command in flight at a time.

Parameters:
- DATA_W, 8, data width; must match the RAM word width.
- NUM_LOC, 2, number of valid RAM locations; addresses >= NUM_LOC are errors.
- INIT_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = go straight to IDLE.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  2  target location.
- cmd_data  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  DATA_W  read data, or the echoed write data.
- rsp_err  out  1  command failed.
- busy  out  1  high in every state except IDLE.
- mem_rw  out  1  to RAM rw; 1 = write.
- mem_endereco  out  2  to RAM endereco.
- mem_data_in  out  DATA_W  to RAM data_in.
- mem_data_out  in  DATA_W  from RAM data_out.

Behaviour:
- Reset (clear==0 at a rising edge):
  - Aborts any operation.
  - Outputs go to: cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mem_rw=0, mem_endereco=0, mem_data_in=0, busy=1.
  - Next state is INIT0 if INIT_ON_RESET=1, otherwise IDLE.
  - Reset wins over every simultaneous event, including a pending mem_rw pulse.
- INIT0: mem_endereco=0, mem_data_in=0, mem_rw=1 for one cycle, then INIT1.
- INIT1: same with mem_endereco=1, then IDLE. Zero-fill takes 2 cycles. cmd_ready stays 0 throughout.
- IDLE:
  - cmd_ready=1, mem_rw=0, busy=0.
  - Accept occurs on cmd_valid&&cmd_ready at edge E0; cmd_write, cmd_addr and cmd_data are latched at E0.
  - If cmd_addr >= NUM_LOC: go to RESP with rsp_err=1, rsp_data=0. The RAM is not touched (mem_rw stays 0).
  - Else if the command is a write: go to WR.
  - Else: go to RD_A.
- WR:
  - mem_endereco=addr, mem_data_in=data, mem_rw=1 for exactly one cycle.
  - At E1, load rsp_data=data, rsp_err=0, and go to RESP.
  - rsp_valid is high in the cycle after E1 (write latency 1 cycle after accept).
- RD_A:
  - mem_endereco=addr, mem_rw=0.
  - Address is held so RAM output settles; go to RD_C.
- RD_C:
  - mem_endereco still =addr.
  - At E2, capture mem_data_out into rsp_data, rsp_err=0, go to RESP.
  - Read latency is 2 cycles after accept.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err stay stable while rsp_ready=0 (no bound on the stall).
  - On rsp_valid&&rsp_ready: rsp_valid=0 next cycle, return to IDLE.
  - The earliest next accept is the cycle after the return to IDLE; there is no back-to-back overlap.
- mem_rw is 1 only in INIT0, INIT1 and WR.
- mem_endereco and mem_data_in keep their last values in other states. mem_endereco is never 2 or 3.
- cmd_* inputs are ignored while cmd_ready=0.
- A cmd_valid that drops before acceptance has no effect.

Optional Feature:
- Macro: RAM_2X8_CTRL_READBACK_VERIFY_EN.
- Defined:
  - WR is followed by VF_A then VF_C, with the same timing as RD_A/RD_C.
  - VF_C compares mem_data_out with the written data; a mismatch sets rsp_err=1.
  - rsp_data=written data in both cases.
  - Write latency becomes 3 cycles.
- Undefined:
  - VF_A and VF_C do not exist.
  - rsp_err is set only for an out-of-range address.

Test Plan:
- Reset with INIT_ON_RESET=1, release clear: mem_rw high for 2 cycles at addresses 0 then 1 with data 0x00; cmd_ready rises on the 3rd cycle; read of addr 0 -> rsp_data=0x00, rsp_err=0.
- Write 0xA5 to addr 1, then read addr 1 and addr 0: write rsp_valid 1 cycle after accept with rsp_data=0xA5; reads return 0xA5 and 0x00; read rsp_valid 2 cycles after accept.
- Write 0x3C to addr 2 and read addr 3: mem_rw never asserts; each gets a response with rsp_err=1, rsp_data=0x00.
- Hold rsp_ready=0 for 5 cycles after a read of 0x5A: rsp_valid, rsp_data=0x5A and cmd_ready=0 stable throughout; new cmd_valid ignored until the handshake completes.
- Assert clear in the WR cycle of a write of 0xFF to addr 0: next cycle mem_rw=0, rsp_valid=0; after init, read addr 0 -> 0x00.
- With RAM_2X8_CTRL_READBACK_VERIFY_EN defined and the bench forcing mem_data_out=0x00 in VF_C after writing 0x81: rsp_err=1, response 3 cycles after accept.
